// File: rtl/disp_chan_scan.sv
// Display-channel selector: muxes the channel-0 latch, test channels and a register tap onto one registered word.
// Defining DISP_AUTOSCAN_EN adds an auto-scan mode (ctrl[4:0]=5'h1F) that rotates through channels every DWELL_CYC clocks.
module disp_chan_scan #(
    parameter int                 DATA_W    = 32,
    parameter int                 N_CH      = 8,
    parameter int                 DWELL_CYC = 50_000_000,
    parameter logic [DATA_W-1:0]  INIT_VAL  = 32'hAA5555AA,
    parameter logic [DATA_W-1:0]  BLANK_VAL = 32'hFFFFFFFF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [5:0]               ctrl,
    input  logic [N_CH*DATA_W-1:0]   ch_data,
    input  logic [DATA_W-1:0]        reg_data,
    input  logic                     scan_hold,
    output logic [DATA_W-1:0]        seg7_data,
    output logic [4:0]               cur_ch,
    output logic                     ch_chg
);

    localparam int CNT_W = $clog2(DWELL_CYC);

    logic [DATA_W-1:0] r_latch;
    logic [DATA_W-1:0] w_selData;
    logic [DATA_W-1:0] w_chWord;
    logic [4:0]        w_selCh;
    logic [4:0]        w_chIdx;
    logic              w_useCh;
    logic              w_unused;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_latch <= INIT_VAL;
        end else if (wr_en) begin
            r_latch <= wr_data;
        end
    end

`ifdef DISP_AUTOSCAN_EN
    logic [4:0]       r_scanCh;
    logic [CNT_W-1:0] r_dwellCnt;
    logic             w_scanMode;

    assign w_scanMode = !ctrl[5] && (ctrl[4:0] == 5'h1F);
    assign w_unused   = ^ch_data[DATA_W-1:0];

    // Outside scan mode the scan state is parked at zero so every entry starts on channel 0 with a full dwell.
    always_ff @(posedge clk) begin
        if (!rst_n || !w_scanMode) begin
            r_scanCh   <= '0;
            r_dwellCnt <= '0;
        end else if (!scan_hold) begin
            if (r_dwellCnt == CNT_W'(DWELL_CYC - 1)) begin
                r_dwellCnt <= '0;
                r_scanCh   <= (r_scanCh == 5'(N_CH - 1)) ? 5'd0 : r_scanCh + 5'd1;
            end else begin
                r_dwellCnt <= r_dwellCnt + CNT_W'(1);
            end
        end
    end
`else
    assign w_unused = ^{scan_hold, ch_data[DATA_W-1:0]};
`endif

    always_comb begin
        w_selData = BLANK_VAL;
        w_selCh   = 5'h1F;
        w_chIdx   = ctrl[4:0];
        w_useCh   = 1'b0;
        if (ctrl[5]) begin
            w_selData = reg_data;
        end
`ifdef DISP_AUTOSCAN_EN
        else if (ctrl[4:0] == 5'h1F) begin
            w_chIdx = r_scanCh;
            w_useCh = 1'b1;
        end
`endif
        else if (ctrl[4:0] < 5'(N_CH)) begin
            w_useCh = 1'b1;
        end
        if (w_useCh) begin
            w_selData = w_chWord;
            w_selCh   = w_chIdx;
        end
    end

    // Constant-index loop avoids a variable part-select into the packed channel bus.
    always_comb begin
        w_chWord = BLANK_VAL;
        if (w_chIdx == 5'd0) begin
            w_chWord = r_latch;
        end
        for (int i = 1; i < N_CH; i++) begin
            if (w_chIdx == 5'(i)) begin
                w_chWord = ch_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg7_data <= INIT_VAL;
            cur_ch    <= 5'd0;
            ch_chg    <= 1'b0;
        end else begin
            seg7_data <= w_selData;
            cur_ch    <= w_selCh;
            ch_chg    <= (w_selCh != cur_ch);
        end
    end

endmodule

// File: tb/tb_disp_chan_scan.sv
// Scoreboard bench for disp_chan_scan (N_CH=4, DWELL_CYC=4); covers both DISP_AUTOSCAN_EN builds.
module tb_disp_chan_scan;

    localparam int DATA_W = 32;
    localparam int N_CH   = 4;
    localparam int DWELL  = 4;
    localparam logic [31:0] INIT  = 32'hAA5555AA;
    localparam logic [31:0] BLANK = 32'hFFFFFFFF;

    logic              clk;
    logic              rst_n;
    logic              wr_en;
    logic [31:0]       wr_data;
    logic [5:0]        ctrl;
    logic [N_CH*32-1:0] ch_data;
    logic [31:0]       reg_data;
    logic              scan_hold;
    logic [31:0]       seg7_data;
    logic [4:0]        cur_ch;
    logic              ch_chg;

    typedef struct {
        logic [31:0] seg;
        logic [4:0]  ch;
        logic        chg;
        string       name;
    } exp_t;

    exp_t expQ[$];
    int   checksTotal  = 0;
    int   checksPassed = 0;

    disp_chan_scan #(
        .DATA_W(DATA_W), .N_CH(N_CH), .DWELL_CYC(DWELL),
        .INIT_VAL(INIT), .BLANK_VAL(BLANK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .ctrl(ctrl), .ch_data(ch_data), .reg_data(reg_data),
        .scan_hold(scan_hold), .seg7_data(seg7_data), .cur_ch(cur_ch),
        .ch_chg(ch_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-entered channel contents; channel 0 is the latch value the caller expects at that point.
    function automatic logic [31:0] chanWord(input int ch, input logic [31:0] latchVal);
        case (ch)
            0:       return latchVal;
            1:       return 32'h00000111;
            2:       return 32'h00000222;
            3:       return 32'h00000333;
            default: return BLANK;
        endcase
    endfunction

    task automatic checkOutput(input exp_t e);
        checksTotal += 3;
        if (seg7_data === e.seg) checksPassed++;
        else $display("[TB] FAIL %s.seg7_data got %h want %h", e.name, seg7_data, e.seg);
        if (cur_ch === e.ch) checksPassed++;
        else $display("[TB] FAIL %s.cur_ch got %h want %h", e.name, cur_ch, e.ch);
        if (ch_chg === e.chg) checksPassed++;
        else $display("[TB] FAIL %s.ch_chg got %b want %b", e.name, ch_chg, e.chg);
    endtask

    // Drives one clock of inputs and queues the outputs expected right after that edge.
    task automatic applyStimulus(input logic rst, input logic we, input logic [31:0] wd,
                                 input logic [5:0] c, input logic hold,
                                 input logic [31:0] eSeg, input logic [4:0] eCh,
                                 input logic eChg, input string name);
        exp_t e;
        rst_n     = rst;
        wr_en     = we;
        wr_data   = wd;
        ctrl      = c;
        scan_hold = hold;
        e.seg  = eSeg;
        e.ch   = eCh;
        e.chg  = eChg;
        e.name = name;
        expQ.push_back(e);
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        if (expQ.size() != 0) begin
            checkOutput(expQ.pop_front());
        end
    end

    initial begin
        int waitCyc;
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;
        ctrl      = 6'd0;
        scan_hold = 1'b0;
        reg_data  = 32'hCAFE0005;
        ch_data   = {32'h00000333, 32'h00000222, 32'h00000111, 32'hBAD00000};

        applyStimulus(0, 1, 32'h12345678, 6'd0, 0, INIT, 5'd0, 0, "reset0");
        applyStimulus(0, 1, 32'h12345678, 6'd0, 0, INIT, 5'd0, 0, "reset1");
        applyStimulus(1, 0, 32'h0,        6'd0, 0, INIT, 5'd0, 0, "release");

        applyStimulus(1, 1, 32'hDEADBEEF, 6'd0, 0, INIT,         5'd0, 0, "wrEdge");
        applyStimulus(1, 0, 32'h0,        6'd0, 0, 32'hDEADBEEF, 5'd0, 0, "wrShow");
        applyStimulus(1, 0, 32'h0,        6'd0, 0, 32'hDEADBEEF, 5'd0, 0, "wrHold");
        applyStimulus(1, 1, 32'h11111111, 6'd0, 0, 32'hDEADBEEF, 5'd0, 0, "wrBurst0");
        applyStimulus(1, 1, 32'h22222222, 6'd0, 0, 32'h11111111, 5'd0, 0, "wrBurst1");
        applyStimulus(1, 0, 32'h0,        6'd0, 0, 32'h22222222, 5'd0, 0, "wrLast");

        applyStimulus(1, 0, 0, 6'd3,       0, 32'h00000333, 5'd3,  1, "sel3");
        applyStimulus(1, 0, 0, 6'd3,       0, 32'h00000333, 5'd3,  0, "sel3Hold");
        applyStimulus(1, 0, 0, 6'd9,       0, BLANK,        5'h1F, 1, "sel9");
        applyStimulus(1, 0, 0, 6'd4,       0, BLANK,        5'h1F, 0, "selNch");
        applyStimulus(1, 0, 0, 6'b100101,  0, 32'hCAFE0005, 5'h1F, 0, "regTap");
        applyStimulus(1, 0, 0, 6'b100000,  0, 32'hCAFE0005, 5'h1F, 0, "regTap0");
        applyStimulus(1, 0, 0, 6'd1,       0, 32'h00000111, 5'd1,  1, "sel1");
        applyStimulus(1, 0, 0, 6'd0,       0, 32'h22222222, 5'd0,  1, "sel0");

`ifdef DISP_AUTOSCAN_EN
        for (int i = 0; i <= 16; i++) begin
            int ch = (i / 4) % 4;
            applyStimulus(1, 0, 0, 6'h1F, 0, chanWord(ch, 32'h22222222), 5'(ch),
                          (i > 0) && (i % 4 == 0), "scan");
        end
        for (int j = 0; j < 6; j++) begin
            applyStimulus(1, 0, 0, 6'h1F, (j >= 2 && j <= 4), 32'h22222222, 5'd0, 0, "scanHold");
        end
        applyStimulus(1, 0, 0, 6'h1F, 0, 32'h00000111, 5'd1, 1, "holdAdv");
        for (int j = 0; j < 3; j++) begin
            applyStimulus(1, 0, 0, 6'h1F, 0, 32'h00000111, 5'd1, 0, "holdCh1");
        end
        applyStimulus(1, 0, 0, 6'h1F, 0, 32'h00000222, 5'd2, 1, "scanCh2");
        applyStimulus(0, 0, 0, 6'h1F, 0, INIT, 5'd0, 0, "midReset");
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1, 0, 0, 6'h1F, 0, INIT, 5'd0, 0, "postReset");
        end
        applyStimulus(1, 0, 0, 6'h1F, 0, 32'h00000111, 5'd1, 1, "postResetAdv");
        applyStimulus(1, 0, 0, 6'd3,  0, 32'h00000333, 5'd3, 1, "leaveScan");
        applyStimulus(1, 0, 0, 6'h1F, 0, INIT, 5'd0, 1, "reenter");
        for (int j = 0; j < 3; j++) begin
            applyStimulus(1, 0, 0, 6'h1F, 0, INIT, 5'd0, 0, "reenterCh0");
        end
        applyStimulus(1, 0, 0, 6'h1F, 0, 32'h00000111, 5'd1, 1, "reenterAdv");
`else
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 0, 0, 6'h1F, 1'(i % 2), BLANK, 5'h1F, (i == 0), "noScan");
        end
`endif

        waitCyc = 0;
        while (expQ.size() != 0 && waitCyc < 10) begin
            @(negedge clk);
            #1;
            waitCyc++;
        end
        if (expQ.size() != 0) begin
            checksTotal++;
            $display("[TB] FAIL drain queue left %0d entries want 0", expQ.size());
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
